// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and helpers for the parity-protected LFSR.
// Holds default WIDTH/TAPS/SEED and the even-parity reduction function.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 7;

  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 7'b110_0000;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 7'b000_0001;

  // Even-parity bit: XOR reduction, so {p, v} has an even count of ones.
  function automatic logic parity_even(
    input logic [LFSR_WIDTH-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci shift-left LFSR with lock-up guard and sync reset.
// Ports: clk, rst (sync, active-high), state_o = current LFSR state.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned           WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]      TAPS  = LFSR_TAPS,
  parameter logic [WIDTH-1:0]      SEED  = LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] state_o
);

  if (SEED == '0 || !TAPS[WIDTH-1]) begin : g_bad_params
    $error("lfsr_core: SEED must be non-zero and TAPS MSB set");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             fb;

  always_comb begin
    fb      = ^(state_q & TAPS);
    state_d = {state_q[WIDTH-2:0], fb};
    // All-zero is a fixed point of the XOR feedback; only an upset
    // can get us here, so reload the seed to restart the sequence.
    if (state_q == '0) begin
      state_d = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_parity.sv
// lfsr_parity: free-running LFSR word with an even-parity MSB appended.
// Ports: clk, rst (sync, active-high), lfsr_out = {parity, state}.
module lfsr_parity
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
  input  logic           clk,
  input  logic           rst,
  output logic [WIDTH:0] lfsr_out
);

  logic [WIDTH-1:0] state;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .state_o (state)
  );

  // Parity is combinational from the register, no extra stage.
  assign lfsr_out = {parity_even(state), state};

endmodule

// File: tb/tb_lfsr_parity.sv
// tb_lfsr_parity: directed scoreboard bench for lfsr_parity.
// Expected words are queued on each drive and popped after each edge.
module tb_lfsr_parity;

  logic       clk;
  logic       rst;
  logic [7:0] lfsr_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb_q[$];
  logic [6:0] m_q;
  bit         seen [128];

  lfsr_parity dut (
    .clk      (clk),
    .rst      (rst),
    .lfsr_out (lfsr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] model_next(input logic [6:0] q);
    if (q == 7'd0) return 7'b000_0001;
    return {q[5:0], q[6] ^ q[5]};
  endfunction

  function automatic logic [7:0] model_word(input logic [6:0] q);
    logic [31:0] n;
    n = $countones(q);
    return {n[0], q};
  endfunction

  // Advance the model for one edge with reset level r.
  function automatic logic [7:0] model_step(input logic r);
    if (r) m_q = 7'b000_0001;
    else   m_q = model_next(m_q);
    return model_word(m_q);
  endfunction

  task automatic step(input logic r, input logic [7:0] exp,
                      input string tag);
    logic [7:0] e;
    sb_q.push_back(exp);
    rst = r;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (lfsr_out === e) else begin
      errors++;
      $error("FAIL %s: got %02h want %02h", tag, lfsr_out, e);
    end
  endtask

  task automatic check_parity(input string tag);
    logic [31:0] n;
    n = $countones(lfsr_out);
    checks++;
    assert (n[0] === 1'b0 && !$isunknown(lfsr_out)) else begin
      errors++;
      $error("FAIL %s: got %02h want even popcount", tag, lfsr_out);
    end
  endtask

  logic [7:0] seq_tab [8] = '{8'h82, 8'h84, 8'h88, 8'h90,
                              8'hA0, 8'h41, 8'h03, 8'h06};

  initial begin
    rst = 1'b1;
    m_q = 7'b000_0001;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      void'(model_step(1'b1));
      step(1'b1, 8'h81, "reset_hold");
    end

    // Known opening sequence.
    for (int i = 0; i < 8; i++) begin
      void'(model_step(1'b0));
      step(1'b0, seq_tab[i], "seq");
    end

    // Full period from reset: 127 distinct non-zero states.
    void'(model_step(1'b1));
    step(1'b1, 8'h81, "period_reset");
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    seen[lfsr_out[6:0]] = 1'b1;
    for (int i = 1; i <= 127; i++) begin
      step(1'b0, model_step(1'b0), "period_seq");
      if (i < 127) begin
        checks++;
        assert (lfsr_out[6:0] !== 7'd0 && !seen[lfsr_out[6:0]]) else begin
          errors++;
          $error("FAIL period_distinct: got %02h want new nonzero", lfsr_out);
        end
        seen[lfsr_out[6:0]] = 1'b1;
      end
    end
    checks++;
    assert (lfsr_out === 8'h81) else begin
      errors++;
      $error("FAIL period_wrap: got %02h want 81", lfsr_out);
    end

    // Parity invariant over 300 cycles.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, model_step(1'b0), "run300");
      check_parity("parity");
    end

    // Mid-run reset pulse at edge 50.
    void'(model_step(1'b1));
    step(1'b1, 8'h81, "mid_pre_reset");
    for (int i = 0; i < 49; i++) begin
      step(1'b0, model_step(1'b0), "mid_run");
    end
    void'(model_step(1'b1));
    step(1'b1, 8'h81, "mid_reset");
    void'(model_step(1'b0));
    step(1'b0, 8'h82, "mid_release");

    // Lock-up recovery: upset the state register to zero.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, model_step(1'b0), "pre_lock");
    end
    @(negedge clk);
    force dut.u_core.state_q = 7'd0;
    #1;
    checks++;
    assert (lfsr_out === 8'h00) else begin
      errors++;
      $error("FAIL lock_forced: got %02h want 00", lfsr_out);
    end
    release dut.u_core.state_q;
    m_q = 7'd0;
    void'(model_step(1'b0));
    step(1'b0, 8'h81, "lock_recover");
    void'(model_step(1'b0));
    step(1'b0, 8'h82, "lock_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
